// File: rtl/matmul_pkg.sv
// Shared definitions for the single-MAC matrix-multiply scheduler:
// matrix size, address width, counter widths, FSM states and the
// row-major address helper.
package matmul_pkg;

  localparam int N          = 4;
  localparam int AW         = 4;
  localparam int CNTW       = 16;
  localparam int CW         = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_STRIDE = N;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Row-major address row*N + col, evaluated in AW bits.
  function automatic logic [AW-1:0] mat_addr(input logic [CW-1:0] row,
                                             input logic [CW-1:0] col);
    logic [AW-1:0] r;
    logic [AW-1:0] c;
    logic [AW-1:0] s;
    r = AW'(row);
    c = AW'(col);
    s = AW'(ROW_STRIDE);
    return r * s + c;
  endfunction

endpackage

// File: rtl/matmul_index_ctr.sv
// Nested i/j/k loop counters for the scheduler. k walks the inner
// (dot-product) index, j/i walk the output element in row-major order.
// Each counter wraps from N-1 to 0; *_nxt expose the post-step values so
// the scheduler can register addresses for the coming cycle.
module matmul_index_ctr
  import matmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          k_step,
  input  logic          ij_step,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] i_nxt,
  output logic [CW-1:0] j_nxt,
  output logic [CW-1:0] k_nxt,
  output logic          k_last,
  output logic          elem_last
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] k;
  logic          j_last;

  // Wrap detection and next-value computation for all three counters.
  always_comb begin
    k_last    = (k == LAST);
    j_last    = (j == LAST);
    elem_last = (i == LAST) && j_last;
    k_nxt     = k_last ? '0 : k + CW'(1);
    j_nxt     = j_last ? '0 : j + CW'(1);
    i_nxt     = i;
    if (j_last) begin
      i_nxt = (i == LAST) ? '0 : i + CW'(1);
    end
  end

  // Counter registers: reset/clear win, otherwise step on request.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (k_step) begin
        k <= k_nxt;
      end
      if (ij_step) begin
        j <= j_nxt;
        i <= i_nxt;
      end
    end
  end

endmodule

// File: rtl/matmul_scheduler.sv
// Single-MAC matrix multiply sequencer C = A x W (N x N, row-major).
// Per element: N FETCH cycles issue reads, one DRAIN cycle lets the
// last product accumulate, one WRITE cycle stores the result.
// All outputs are registered. Read data arrives one cycle after the
// address, so mac_en/mac_clr are the read strobes delayed by one cycle.
// Optional build macro MATMUL_SCHED_PERF_EN adds the perf_cycles
// busy-cycle counter port.
module matmul_scheduler
  import matmul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load_active,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rd_en_A,
  output logic [AW-1:0]   addr_A,
  output logic            rd_en_W,
  output logic [AW-1:0]   addr_W,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            res_wr,
  output logic [AW-1:0]   res_addr,
`ifdef MATMUL_SCHED_PERF_EN
  output logic [CNTW-1:0] perf_cycles,
`endif
  output state_t          state_dbg
);

  state_t        state;
  logic          rd_first;
  logic          accept;
  logic          ctr_k_step;
  logic          ctr_ij_step;
  logic [CW-1:0] i;
  logic [CW-1:0] j;
  logic [CW-1:0] i_nxt;
  logic [CW-1:0] j_nxt;
  logic [CW-1:0] k_nxt;
  logic          k_last;
  logic          elem_last;

  assign state_dbg = state;

  // Counter control decoded from the current state.
  always_comb begin
    accept      = (state == IDLE) && start && !load_active;
    ctr_k_step  = (state == FETCH);
    ctr_ij_step = (state == WRITE);
  end

  matmul_index_ctr u_idx (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .k_step    (ctr_k_step),
    .ij_step   (ctr_ij_step),
    .i         (i),
    .j         (j),
    .i_nxt     (i_nxt),
    .j_nxt     (j_nxt),
    .k_nxt     (k_nxt),
    .k_last    (k_last),
    .elem_last (elem_last)
  );

  // Main FSM: state, read strobes/addresses, result write, busy/done/err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_en_A  <= 1'b0;
      rd_en_W  <= 1'b0;
      addr_A   <= '0;
      addr_W   <= '0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      rd_first <= 1'b0;
    end else begin
      rd_en_A  <= 1'b0;
      rd_en_W  <= 1'b0;
      addr_A   <= '0;
      addr_W   <= '0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      done     <= 1'b0;
      rd_first <= 1'b0;
      if (busy && load_active) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
            rd_en_A  <= 1'b1;
            rd_en_W  <= 1'b1;
            rd_first <= 1'b1;
          end
        end
        FETCH: begin
          if (k_last) begin
            state <= DRAIN;
          end else begin
            rd_en_A <= 1'b1;
            rd_en_W <= 1'b1;
            addr_A  <= mat_addr(i, k_nxt);
            addr_W  <= mat_addr(k_nxt, j);
          end
        end
        DRAIN: begin
          state    <= WRITE;
          res_wr   <= 1'b1;
          res_addr <= mat_addr(i, j);
        end
        WRITE: begin
          if (elem_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= FETCH;
            rd_en_A  <= 1'b1;
            rd_en_W  <= 1'b1;
            rd_first <= 1'b1;
            addr_A   <= mat_addr(i_nxt, '0);
            addr_W   <= mat_addr('0, j_nxt);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // MAC strobes follow the read strobes by the memory read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
    end else begin
      mac_en  <= rd_en_A;
      mac_clr <= rd_en_A && rd_first;
    end
  end

`ifdef MATMUL_SCHED_PERF_EN
  // Saturating count of busy cycles, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != {CNTW{1'b1}})) begin
      perf_cycles <= perf_cycles + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_matmul_scheduler.sv
// Bench for matmul_scheduler: behavioural 1-cycle-latency A/W memories
// and accumulator, an arithmetic model of the expected schedule and of
// C = A x W, randomized matrices, load_active glitches and start noise.
// Build with MATMUL_SCHED_PERF_EN defined to also cover perf_cycles.
module tb_matmul_scheduler;
  import matmul_pkg::*;

  localparam int RUN_CYCLES = N * N * (N + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          load_active = 1'b0;
  logic          busy, done, err;
  logic          rd_en_A, rd_en_W, mac_en, mac_clr, res_wr;
  logic [AW-1:0] addr_A, addr_W, res_addr;
  state_t        state_dbg;
`ifdef MATMUL_SCHED_PERF_EN
  logic [CNTW-1:0] perf_cycles;
`endif

  int total = 0;
  int bad   = 0;

  int a_mem [N*N];
  int w_mem [N*N];
  int data_a, data_w, acc;

  logic [31:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  matmul_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_active (load_active),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rd_en_A     (rd_en_A),
    .addr_A      (addr_A),
    .rd_en_W     (rd_en_W),
    .addr_W      (addr_W),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr),
    .res_wr      (res_wr),
    .res_addr    (res_addr),
`ifdef MATMUL_SCHED_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .state_dbg   (state_dbg)
  );

  // Behavioural memories with registered read and the MAC accumulator.
  always @(posedge clk) begin
    if (rd_en_A) data_a <= a_mem[addr_A];
    if (rd_en_W) data_w <= w_mem[addr_W];
    if (mac_en) acc <= mac_clr ? data_a * data_w : acc + data_a * data_w;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_word();
    return 32'({rd_en_A, rd_en_W, addr_A, addr_W, mac_en, mac_clr,
                res_wr, res_addr, busy, done});
  endfunction

  // Expected strobes c cycles after the accepted start edge.
  function automatic logic [31:0] exp_word(input int c);
    int e, p, ei, ej;
    logic rd, me, mc, rwr, b, d;
    logic [AW-1:0] aa, aw, ra;
    rd = 0; me = 0; mc = 0; rwr = 0; b = 0; d = 0;
    aa = '0; aw = '0; ra = '0;
    if (c >= 1 && c <= RUN_CYCLES) begin
      e  = (c - 1) / (N + 2);
      p  = (c - 1) % (N + 2);
      ei = e / N;
      ej = e % N;
      b  = 1;
      if (p < N) begin
        rd = 1;
        aa = AW'(ei * N + p);
        aw = AW'(p * N + ej);
      end
      me = (p >= 1) && (p <= N);
      mc = (p == 1);
      if (p == N + 1) begin
        rwr = 1;
        ra  = AW'(e);
      end
    end
    d = (c == RUN_CYCLES + 1);
    return 32'({rd, rd, aa, aw, me, mc, rwr, ra, b, d});
  endfunction

  // Reference product pushed into the scoreboard in row-major order.
  function automatic void model_push();
    int s;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += a_mem[r*N + k] * w_mem[k*N + c];
        exp_q.push_back(32'(s));
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_plan_data();
    int wrow [N*N];
    wrow = '{4,0,2,1, 4,3,2,0, 4,3,0,1, 4,3,2,1};
    for (int x = 0; x < N*N; x++) begin
      w_mem[x] = wrow[x];
      a_mem[x] = (x % N) + 1;
    end
  endtask

  task automatic load_random_data();
    for (int x = 0; x < N*N; x++) begin
      a_mem[x] = $urandom_range(0, 255);
      w_mem[x] = $urandom_range(0, 255);
    end
  endtask

  // Start a run from IDLE (called at a negedge) and check every cycle.
  // glitch_c: cycle with load_active high (0 = none); rst_c: cycle in which
  // reset is asserted (0 = none); noisy: random start while running.
  task automatic do_run(input int glitch_c, input int rst_c, input bit noisy);
    int   got [N*N];
    logic exp_err;
    logic [31:0] e;
    exp_err = 1'b0;
    for (int x = 0; x < N*N; x++) got[x] = -1;
    start = 1'b1;
    load_active = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= RUN_CYCLES + 2; c++) begin
      check_eq("strobes", obs_word(), exp_word(c));
      check_eq("err", err, exp_err);
`ifdef MATMUL_SCHED_PERF_EN
      check_eq("perf", perf_cycles, 32'((c - 1 > RUN_CYCLES) ? RUN_CYCLES : c - 1));
`endif
      if (res_wr) got[res_addr] = acc;
      start = (noisy && c <= RUN_CYCLES + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      load_active = (c == glitch_c);
      if (load_active && c <= RUN_CYCLES) exp_err = 1'b1;
      if (c == rst_c) rst = 1'b0;
      @(negedge clk);
      if (c == rst_c) begin
        check_eq("rst_mid_outputs", obs_word(), 32'd0);
        check_eq("rst_mid_err", err, 1'b0);
        check_eq("rst_mid_mac", {mac_en, mac_clr}, 2'b00);
        check_eq("rst_mid_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b1;
        start = 1'b0;
        load_active = 1'b0;
        @(negedge clk);
        return;
      end
    end
    start = 1'b0;
    load_active = 1'b0;
    check_eq("idle_after_done", 32'(state_dbg), 32'(IDLE));
    check_eq("err_hold", err, exp_err);
    model_push();
    for (int x = 0; x < N*N; x++) begin
      e = exp_q.pop_front();
      check_eq($sformatf("c[%0d]", x), 32'(got[x]), e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", obs_word(), 32'd0);
    check_eq("reset_err", err, 1'b0);
    check_eq("reset_mac", {mac_en, mac_clr}, 2'b00);
    check_eq("reset_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // basic run with the reference matrices
    load_plan_data();
    do_run(0, 0, 1'b0);
`ifdef MATMUL_SCHED_PERF_EN
    repeat (3) @(negedge clk);
    check_eq("perf_hold", perf_cycles, 32'(RUN_CYCLES));
`endif

    // start while loader is active: ignored and not queued
    start = 1'b1;
    load_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq("blocked_busy", busy, 1'b0);
      check_eq("blocked_reads", {rd_en_A, rd_en_W}, 2'b00);
      if (c == 1) load_active = 1'b0;
      @(negedge clk);
    end
    do_run(0, 0, 1'b1);

    // one-cycle load_active glitch mid-run, then clean run clears err
    do_run($urandom_range(1, RUN_CYCLES), 0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("err_sticky_idle", err, 1'b1);
    do_run(0, 0, 1'b0);

    // reset during element 5, then a full run
    do_run(0, 5 * (N + 2) + $urandom_range(1, N + 2), 1'b0);
    do_run(0, 0, 1'b0);

    // randomized matrices with random glitch / start noise
    for (int r = 0; r < 3; r++) begin
      load_random_data();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run((r == 1) ? $urandom_range(1, RUN_CYCLES) : 0, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
